pi_math_unit: RTL



---
 rtl/pi_math_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pi_math_unit.sv
// Sequential math unit for the PI controller: single-cycle signed add/sub with optional
// clamp, and an iterative shift-add fixed-point multiply behind a start/busy/done handshake.
module pi_math_unit #(
    parameter int DW   = 16,
    parameter int SATW = 12,
    parameter int FRAC = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [1:0]    scale,
    input  logic          saturate,
    input  logic [DW-1:0] src1,
    input  logic [DW-1:0] src0,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] dst,
    output logic          ovf
);
    localparam int CW = $clog2(DW);
    localparam logic signed [DW-1:0]   ADD_MAX = DW'((1 << (SATW - 1)) - 1);
    localparam logic signed [DW-1:0]   ADD_MIN = ~ADD_MAX;
    localparam logic signed [2*DW-1:0] MUL_MAX = (2*DW)'((1 << (DW - 2)) - 1);
    localparam logic signed [2*DW-1:0] MUL_MIN = ~MUL_MAX;

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    function automatic logic [DW-1:0] prescale(input logic [DW-1:0] v, input logic [1:0] sc);
        case (sc)
            2'b00:   return v;
            2'b01:   return v << 1;
            default: return v << 2;
        endcase
    endfunction

    function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v);
        return v[DW-1] ? -v : v;
    endfunction

    // Returns {ovf, value}.
    function automatic logic [DW:0] clamp_addsub(input logic signed [DW-1:0] raw, input logic sat);
        if (sat && raw > ADD_MAX) return {1'b1, ADD_MAX};
        if (sat && raw < ADD_MIN) return {1'b1, ADD_MIN};
        return {1'b0, raw};
    endfunction

    // Restores the sign, drops FRAC bits (floor) and clamps to the DW-1 bit signed range.
    function automatic logic [DW:0] finish_mul(input logic [2*DW-1:0] prod, input logic neg);
        logic signed [2*DW-1:0] p;
        p = neg ? -prod : prod;
        p = p >>> FRAC;
        if (p > MUL_MAX) return {1'b1, MUL_MAX[DW-1:0]};
        if (p < MUL_MIN) return {1'b1, MUL_MIN[DW-1:0]};
        return {1'b0, p[DW-1:0]};
    endfunction

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*DW-1:0]      acc;
    logic [DW-1:0]        mcand;
    logic [DW-1:0]        mplier;
    logic                 neg;
    logic [DW-1:0]        s0;
    logic signed [DW-1:0] raw;
    logic [DW:0]          addsub_res;
    logic [DW:0]          mul_res;

    assign s0         = prescale(src0, scale);
    assign raw        = (op == 2'b01) ? src1 - s0 : src1 + s0;
    assign addsub_res = clamp_addsub(raw, saturate);
    assign mul_res    = finish_mul(acc, neg);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && op == 2'b10) state_nxt = MUL;
            MUL:     if (cnt == '0) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst  <= '0;
            ovf  <= 1'b0;
            done <= 1'b0;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == 2'b10) begin
                            mcand  <= magnitude(s0);
                            mplier <= magnitude(src1);
                            neg    <= s0[DW-1] ^ src1[DW-1];
                            acc    <= '0;
                            cnt    <= CW'(DW - 1);
                        end else begin
                            {ovf, dst} <= addsub_res;
                            done       <= 1'b1;
                        end
                    end
                end
                // Multiplier bits consumed MSB first: acc = 2*acc + bit*mcand.
                MUL: begin
                    acc <= (acc << 1) + (mplier[cnt] ? {{DW{1'b0}}, mcand} : '0);
                    cnt <= cnt - CW'(1);
                end
                FIN: begin
                    {ovf, dst} <= mul_res;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
